frame_cmd_scheduler: RTL



---
 rtl/frame_cmd_pkg.sv | 31 +++
 rtl/frame_cmd_fifo.sv | 56 +++++
 rtl/frame_cmd_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_cmd_pkg.sv
// Shared constants and types for the frame command scheduler: opcodes,
// parser/committer state encodings and the staged register-write entry.
package frame_cmd_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DATA_W = 8;

    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_COMMIT = 4'h2;
    localparam logic [3:0] OP_CLEAR  = 4'h3;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_DATA = 2'd1,
        P_SKIP = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_WAIT  = 2'd1,
        C_DRAIN = 2'd2
    } commit_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } reg_entry_t;

    localparam int unsigned ENTRY_W = $bits(reg_entry_t);

endpackage

// File: rtl/frame_cmd_fifo.sv
// Synchronous staging FIFO for register writes; head entry is visible
// combinationally so a pop and its data land in the same cycle.
module frame_cmd_fifo
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/frame_cmd_scheduler.sv
// SPI command parser + vblank-aligned register-write committer.
// Optional FRAME_CMD_AUTO_COMMIT_EN: a vblank in idle with staged writes drains them.
module frame_cmd_scheduler
    import frame_cmd_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              vblank_start,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    output logic              int_out,
    output logic              commit_pending,
    output logic              overflow
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    parse_state_t  p_state, p_next;
    commit_state_t c_state, c_next;

    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  drain_left;
    logic              commit_again;

    logic [3:0]        hdr_op_c;
    logic              write_hdr_c, commit_req_c, clear_req_c, data_byte_c;
    logic              push_c, drop_c;
    logic              pop_c, load_c, done_c, set_again_c;

    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    reg_entry_t        push_entry, head_entry;

    assign hdr_op_c   = byte_data[7:4];
    assign push_c     = data_byte_c & ~fifo_full;
    assign drop_c     = data_byte_c & fifo_full;
    assign push_entry = '{addr: wr_addr, data: byte_data};

    frame_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Parser: state register
    always_ff @(posedge clk) begin
        if (rst) p_state <= P_IDLE;
        else     p_state <= p_next;
    end

    // Parser: chip-select high always returns to idle, even mid-packet
    always_comb begin
        p_next = p_state;
        if (spi_cs_n) begin
            p_next = P_IDLE;
        end else if (p_state == P_IDLE && byte_valid) begin
            p_next = (hdr_op_c == OP_WRITE) ? P_DATA : P_SKIP;
        end
    end

    // Parser: per-byte actions
    always_comb begin
        write_hdr_c  = 1'b0;
        commit_req_c = 1'b0;
        clear_req_c  = 1'b0;
        data_byte_c  = 1'b0;
        if (!spi_cs_n && byte_valid) begin
            case (p_state)
                P_IDLE: begin
                    write_hdr_c  = (hdr_op_c == OP_WRITE);
                    commit_req_c = (hdr_op_c == OP_COMMIT);
                    clear_req_c  = (hdr_op_c == OP_CLEAR);
                end
                P_DATA:  data_byte_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Write address advances on every data byte, including dropped ones
    always_ff @(posedge clk) begin
        if (rst)              wr_addr <= '0;
        else if (write_hdr_c) wr_addr <= byte_data[ADDR_W-1:0];
        else if (data_byte_c) wr_addr <= wr_addr + ADDR_W'(1);
    end

    // Committer: state register
    always_ff @(posedge clk) begin
        if (rst) c_state <= C_IDLE;
        else     c_state <= c_next;
    end

    // Committer: next state
    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE: begin
`ifdef FRAME_CMD_AUTO_COMMIT_EN
                if (vblank_start && !fifo_empty) c_next = C_DRAIN;
                else
`endif
                if (commit_req_c) c_next = C_WAIT;
            end
            C_WAIT: begin
                if (vblank_start) c_next = fifo_empty ? C_IDLE : C_DRAIN;
            end
            C_DRAIN: begin
                if (drain_left == '0) c_next = (commit_again || commit_req_c) ? C_WAIT : C_IDLE;
            end
            default: c_next = C_IDLE;
        endcase
    end

    // Committer: first pop happens on the vblank cycle itself so writes start at t+1
    always_comb begin
        pop_c       = 1'b0;
        load_c      = 1'b0;
        done_c      = 1'b0;
        set_again_c = 1'b0;
        case (c_state)
            C_IDLE: begin
`ifdef FRAME_CMD_AUTO_COMMIT_EN
                if (vblank_start && !fifo_empty) begin
                    pop_c       = 1'b1;
                    load_c      = 1'b1;
                    set_again_c = commit_req_c;
                end
`endif
            end
            C_WAIT: begin
                if (vblank_start) begin
                    if (fifo_empty) begin
                        done_c = 1'b1;
                    end else begin
                        pop_c  = 1'b1;
                        load_c = 1'b1;
                    end
                end
            end
            C_DRAIN: begin
                if (drain_left != '0) begin
                    pop_c       = 1'b1;
                    set_again_c = commit_req_c;
                end else begin
                    done_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // drain_left counts pops still owed after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_left   <= '0;
            commit_again <= 1'b0;
        end else begin
            if (load_c)     drain_left <= fifo_count - CNT_W'(1);
            else if (pop_c) drain_left <= drain_left - CNT_W'(1);
            if (done_c)           commit_again <= 1'b0;
            else if (set_again_c) commit_again <= 1'b1;
        end
    end

    // Registered outputs; interrupt/overflow set takes priority over CLEAR
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_en      <= 1'b0;
            reg_wr_addr    <= '0;
            reg_wr_data    <= '0;
            int_out        <= 1'b0;
            commit_pending <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            reg_wr_en <= pop_c;
            if (pop_c) begin
                reg_wr_addr <= head_entry.addr;
                reg_wr_data <= head_entry.data;
            end
            if (done_c)           int_out <= 1'b1;
            else if (clear_req_c) int_out <= 1'b0;
            if (drop_c)           overflow <= 1'b1;
            else if (clear_req_c) overflow <= 1'b0;
            commit_pending <= (c_next != C_IDLE);
        end
    end

endmodule
